// File: rtl/if_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared constants and types for the instruction-fetch front end.
//   DATA_SIZE        : PC / instruction width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP          : byte increment between sequential instructions
//   present_src_e    : which storage element drives the IF/ID outputs
// -----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam int unsigned DATA_SIZE        = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_STEP          = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_REQ  = 2'd1,
        SRC_HOLD = 2'd2
    } present_src_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_if
// Bundles the fetch unit's control inputs, ROM bus and IF/ID output stream.
//   advance        : IF/ID accepts the presented instruction this cycle
//   redirect_valid : taken branch/jump this cycle
//   redirect_pc    : redirect target (low two bits ignored)
//   rom_req        : ROM read enable
//   rom_addr       : ROM read address, word aligned
//   rom_data       : ROM read data, valid the cycle after rom_req
//   pc_out         : PC of the presented instruction
//   inst_out       : presented instruction
//   valid_out      : pc_out/inst_out valid; transfer = valid_out & advance
// master modport = fetch unit side, slave modport = environment side.
// -----------------------------------------------------------------------------
interface if_fetch_unit_if
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = DATA_SIZE
);

    logic            advance;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            rom_req;
    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_data;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] inst_out;
    logic            valid_out;

    modport master (
        input  advance,
        input  redirect_valid,
        input  redirect_pc,
        input  rom_data,
        output rom_req,
        output rom_addr,
        output pc_out,
        output inst_out,
        output valid_out
    );

    modport slave (
        output advance,
        output redirect_valid,
        output redirect_pc,
        output rom_data,
        input  rom_req,
        input  rom_addr,
        input  pc_out,
        input  inst_out,
        input  valid_out
    );

endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_unit_hold_buf
// One-entry {pc, inst} hold buffer for stall-tolerant pipeline stages.
//   i_clk, i_rst : clock, synchronous active-high reset (clears all fields)
//   i_load       : capture i_pc/i_inst and set valid
//   i_clear      : drop the held entry (wins over i_load)
//   i_pc, i_inst : entry to capture
//   o_valid      : an entry is held
//   o_pc, o_inst : held entry
// -----------------------------------------------------------------------------
module if_fetch_unit_hold_buf #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_load,
    input  logic            i_clear,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_inst,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_inst
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;

endmodule

// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end: owns the PC, issues reads to a synchronous
// instruction ROM (1-cycle latency), follows branch-unit redirects and the
// hazard unit's advance, and presents a PC/instruction stream to IF/ID.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   io_fetch : if_fetch_unit_if.master (advance, redirect, ROM bus, IF/ID out)
// Parameters: XLEN (PC/instruction width), RESET_PC (first fetch address).
// At most one word is ever outstanding: either a ROM read in flight
// (r_req_pending) or a word parked in the hold buffer, never both.
// -----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = DATA_SIZE,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    if_fetch_unit_if.master  io_fetch
);

    logic [XLEN-1:0] r_fetch_pc;
    logic            r_req_pending;
    logic [XLEN-1:0] r_req_pc;

    logic            w_hold_valid;
    logic [XLEN-1:0] w_hold_pc;
    logic [XLEN-1:0] w_hold_inst;
    logic            w_hold_load;
    logic            w_hold_clear;

    logic            w_valid_int;
    logic            w_issue;
    logic [XLEN-1:0] w_redirect_tgt;
    logic [XLEN-1:0] w_rom_addr;
    present_src_e    w_src;

    assign w_redirect_tgt = io_fetch.redirect_pc & ~XLEN'(3);
    assign w_valid_int    = w_hold_valid | r_req_pending;

    // A new read goes out whenever the current word leaves (advance), is
    // thrown away (redirect), or there is nothing outstanding.
    assign w_issue    = !i_rst & (io_fetch.redirect_valid | io_fetch.advance | !w_valid_int);
    assign w_rom_addr = io_fetch.redirect_valid ? w_redirect_tgt : r_fetch_pc;

    // Park the returning word when the decoder stalls; the ROM data is only
    // valid for one cycle, so it must be captured now or lost.
    assign w_hold_load  = r_req_pending & !w_hold_valid & !io_fetch.advance
                        & !io_fetch.redirect_valid;
    assign w_hold_clear = io_fetch.redirect_valid | (w_hold_valid & io_fetch.advance);

    if_fetch_unit_hold_buf #(
        .XLEN (XLEN)
    ) u_hold_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_hold_load),
        .i_clear (w_hold_clear),
        .i_pc    (r_req_pc),
        .i_inst  (io_fetch.rom_data),
        .o_valid (w_hold_valid),
        .o_pc    (w_hold_pc),
        .o_inst  (w_hold_inst)
    );

    // When no read issues the pending word was either consumed or moved to
    // the hold buffer, so the in-flight flag always drops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc    <= RESET_PC;
            r_req_pending <= 1'b0;
            r_req_pc      <= '0;
        end else if (w_issue) begin
            r_req_pending <= 1'b1;
            r_req_pc      <= w_rom_addr;
            r_fetch_pc    <= w_rom_addr + XLEN'(PC_STEP);
        end else begin
            r_req_pending <= 1'b0;
        end
    end

    always_comb begin
        w_src = SRC_NONE;
        if (w_hold_valid) begin
            w_src = SRC_HOLD;
        end else if (r_req_pending) begin
            w_src = SRC_REQ;
        end
    end

    always_comb begin
        io_fetch.pc_out   = '0;
        io_fetch.inst_out = '0;
        case (w_src)
            SRC_HOLD: begin
                io_fetch.pc_out   = w_hold_pc;
                io_fetch.inst_out = w_hold_inst;
            end
            SRC_REQ: begin
                io_fetch.pc_out   = r_req_pc;
                io_fetch.inst_out = io_fetch.rom_data;
            end
            default: begin
                io_fetch.pc_out   = '0;
                io_fetch.inst_out = '0;
            end
        endcase
    end

    // A redirect marks whatever is presented as wrong-path.
    assign io_fetch.valid_out = (w_src != SRC_NONE) & !io_fetch.redirect_valid & !i_rst;
    assign io_fetch.rom_req   = w_issue;
    assign io_fetch.rom_addr  = w_rom_addr;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.XLEN(XLEN)) bus ();

    if_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RST_PC)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .io_fetch (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    // Synchronous ROM; garbage when not read so stale data is visible.
    always @(posedge clk) begin
        bus.rom_data <= bus.rom_req ? rom_word(bus.rom_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one "next word" slot that is either present or not,
    // and the next sequential address.
    bit          run = 1'b0;
    logic        m_v = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_nxt = RST_PC;
    logic        e_req, e_valid;
    logic [31:0] e_addr;
    logic [31:0] xfer_q[$];
    logic [31:0] pres_q[$];

    always begin
        @(negedge clk);
        #2;
        if (run) begin
            e_valid = m_v & !bus.redirect_valid & !rst;
            e_req   = !rst & (bus.redirect_valid | bus.advance | !m_v);
            e_addr  = bus.redirect_valid ? (bus.redirect_pc & 32'hFFFF_FFFC) : m_nxt;
            chk("valid_out", 32'(bus.valid_out), 32'(e_valid));
            chk("rom_req", 32'(bus.rom_req), 32'(e_req));
            if (e_req) chk("rom_addr", bus.rom_addr, e_addr);
            if (e_valid) begin
                chk("pc_out", bus.pc_out, m_pc);
                chk("inst_out", bus.inst_out, rom_word(m_pc));
            end
            if (bus.valid_out === 1'b1) begin
                pres_q.push_back(bus.pc_out);
                if (bus.advance === 1'b1) xfer_q.push_back(bus.pc_out);
            end
            if (rst) begin
                m_v   = 1'b0;
                m_nxt = RST_PC;
            end else if (e_req) begin
                m_v   = 1'b1;
                m_pc  = e_addr;
                m_nxt = e_addr + 32'd4;
            end
        end
    end

    task automatic drive(input bit r, input bit a, input bit rv, input logic [31:0] rp);
        @(negedge clk);
        rst                = r;
        bus.advance        = a;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    logic [31:0] exp_xfer [11] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h200,
                                   32'h204, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h4};
    int n_bad;

    initial begin
        bus.advance        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        run = 1'b1;

        // reset, then streaming
        drive(1, 0, 0, 0); #3;
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_req", 32'(bus.rom_req), 32'd0);
        drive(0, 1, 0, 0); #3;
        chk("first_req", 32'(bus.rom_req), 32'd1);
        chk("first_addr", bus.rom_addr, 32'h0);
        drive(0, 1, 0, 0); #3;
        chk("first_valid", 32'(bus.valid_out), 32'd1);
        chk("first_pc", bus.pc_out, 32'h0);
        chk("first_inst", bus.inst_out, 32'h1000_0000);
        drive(0, 1, 0, 0);

        // stall with pc 8 pending
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0); #3;
        chk("stall_pc", bus.pc_out, 32'h8);
        chk("stall_req", 32'(bus.rom_req), 32'd0);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);

        // redirect with advance while pc 16 pending
        drive(0, 1, 1, 32'h0000_0100); #3;
        chk("redir_valid", 32'(bus.valid_out), 32'd0);
        chk("redir_addr", bus.rom_addr, 32'h100);
        drive(0, 1, 0, 0); #3;
        chk("redir_pc", bus.pc_out, 32'h100);

        // redirect while holding, advance low
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 32'h0000_0200); #3;
        chk("hredir_addr", bus.rom_addr, 32'h200);
        drive(0, 0, 0, 0); #3;
        chk("hredir_valid", 32'(bus.valid_out), 32'd1);
        chk("hredir_pc", bus.pc_out, 32'h200);
        drive(0, 0, 0, 0); #3;
        chk("hredir_hold_pc", bus.pc_out, 32'h200);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);

        // unaligned target at top of address space, wrap to 0
        drive(0, 1, 1, 32'hFFFF_FFFE); #3;
        chk("wrap_addr", bus.rom_addr, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0); #3;
        chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap_inst", bus.inst_out, 32'h4FFF_FFFF);
        chk("wrap_next", bus.rom_addr, 32'h0);
        drive(0, 1, 0, 0);

        // reset in the middle of a stall
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0); #3;
        chk("mrst_valid", 32'(bus.valid_out), 32'd0);
        chk("mrst_req", 32'(bus.rom_req), 32'd0);
        drive(0, 1, 0, 0); #3;
        chk("restart_req", 32'(bus.rom_req), 32'd1);
        chk("restart_addr", bus.rom_addr, RST_PC);
        chk("restart_valid", 32'(bus.valid_out), 32'd0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk); #3;
        run = 1'b0;

        // transferred stream in order, each exactly once
        chk("xfer_count", 32'(xfer_q.size()), 32'd11);
        for (int i = 0; i < 11; i++) begin
            if (i < xfer_q.size()) chk($sformatf("xfer[%0d]", i), xfer_q[i], exp_xfer[i]);
        end
        n_bad = 0;
        foreach (pres_q[i]) if (pres_q[i] == 32'h10 || pres_q[i] == 32'h14) n_bad++;
        chk("squashed_presented", 32'(n_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
